// File: rtl/frame_sequencer_pkg.sv
// Shared types and geometry limits for the frame sequencer.
package frame_sequencer_pkg;

    localparam int CNT_W   = 12;
    localparam int FCNT_W  = 16;
    localparam int MIN_DIM = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    // Geometry is usable only if both dimensions can hold a 3x3 kernel.
    function automatic logic geom_ok(input logic [CNT_W-1:0] width,
                                     input logic [CNT_W-1:0] height);
        return (width >= CNT_W'(MIN_DIM)) && (height >= CNT_W'(MIN_DIM));
    endfunction

endpackage

// File: rtl/frame_sequencer_pos.sv
// Pixel/line position tracker with end-of-line and end-of-frame decode.
module frame_pos_counter
    import frame_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat,
    input  logic             clr,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] height,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt,
    output logic             eol,
    output logic             eof
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    assign eol = beat & (x_cnt == (width - ONE));
    assign eof = eol & (y_cnt == (height - ONE));

    // Advance column per beat, wrap to the next line at eol and to line 0 at eof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (clr) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (beat) begin
            if (eol) begin
                x_cnt <= '0;
                y_cnt <= eof ? '0 : (y_cnt + ONE);
            end else begin
                x_cnt <= x_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame-level sequencer: handshake gating, position sideband, run/done control.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SEQ_IDLE | waiting for a start with legal geometry; stream blocked
//   SEQ_RUN  | passing beats, counting pixels/lines/frames
//   SEQ_DONE | one-cycle done pulse after the last requested frame
module frame_sequencer
    import frame_sequencer_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    input  logic [FCNT_W-1:0] cfg_frames,
    input  logic              up_TVALID,
    output logic              up_TREADY,
    output logic              dp_TVALID,
    input  logic              dp_TREADY,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic [CNT_W-1:0]  x_cnt,
    output logic [CNT_W-1:0]  y_cnt,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
);

    localparam logic [FCNT_W-1:0] ONE_F = FCNT_W'(1);

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [CNT_W-1:0] shadow_width;
    logic [CNT_W-1:0] shadow_height;
    logic             running;
    logic             beat;
    logic             start_req;
    logic             start_ok;
    logic             last_frame;
    logic             clr_pos;

    assign running   = (state == SEQ_RUN);
    assign up_TREADY = running & dp_TREADY;
    assign dp_TVALID = running & up_TVALID;
    assign beat      = up_TVALID & up_TREADY;
    assign busy      = (state != SEQ_IDLE);

    // Abort outranks a simultaneous start.
    assign start_req = (state == SEQ_IDLE) & cfg_start & ~cfg_abort;
    assign start_ok  = start_req & geom_ok(cfg_width, cfg_height);
    assign clr_pos   = cfg_abort | start_ok;

    // cfg_frames is read live, so a mid-run rewrite below the count never matches.
    assign last_frame = (cfg_frames != '0) && ((frame_cnt + ONE_F) == cfg_frames);

    assign sof = beat & (x_cnt == '0) & (y_cnt == '0);

    frame_pos_counter u_pos (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .beat   (beat),
        .clr    (clr_pos),
        .width  (shadow_width),
        .height (shadow_height),
        .x_cnt  (x_cnt),
        .y_cnt  (y_cnt),
        .eol    (eol),
        .eof    (eof)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and done pulse.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start_ok) begin
                    state_nxt = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (cfg_abort) begin
                    state_nxt = SEQ_IDLE;
                end else if (eof && last_frame) begin
                    state_nxt = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                done      = 1'b1;
                state_nxt = SEQ_IDLE;
            end
            default: begin
                state_nxt = SEQ_IDLE;
            end
        endcase
    end

    // Shadow geometry, frame counter and sticky config error; geometry only changes at frame boundaries.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            shadow_width  <= '0;
            shadow_height <= '0;
            frame_cnt     <= '0;
            err_cfg       <= 1'b0;
        end else if (start_req) begin
            if (start_ok) begin
                shadow_width  <= cfg_width;
                shadow_height <= cfg_height;
                frame_cnt     <= '0;
                err_cfg       <= 1'b0;
            end else begin
                err_cfg       <= 1'b1;
            end
        end else if (running && eof && !cfg_abort) begin
            shadow_width  <= cfg_width;
            shadow_height <= cfg_height;
            frame_cnt     <= frame_cnt + ONE_F;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with an expected-beat scoreboard.
module tb_frame_sequencer;

    logic        ACLK;
    logic        ARESETn;
    logic        cfg_start;
    logic        cfg_abort;
    logic [11:0] cfg_width;
    logic [11:0] cfg_height;
    logic [15:0] cfg_frames;
    logic        up_TVALID;
    logic        up_TREADY;
    logic        dp_TVALID;
    logic        dp_TREADY;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        done;
    logic        err_cfg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Each entry: {5'b0, sof, eol, eof, x[11:0], y[11:0]}
    logic [31:0] exp_q[$];

    frame_sequencer dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_frames (cfg_frames),
        .up_TVALID  (up_TVALID),
        .up_TREADY  (up_TREADY),
        .dp_TVALID  (dp_TVALID),
        .dp_TREADY  (dp_TREADY),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof),
        .x_cnt      (x_cnt),
        .y_cnt      (y_cnt),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .done       (done),
        .err_cfg    (err_cfg)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start(input int w, input int h, input int frames);
        cfg_width  = 12'(w);
        cfg_height = 12'(h);
        cfg_frames = 16'(frames);
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic push_frame(input int w, input int h);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                exp_q.push_back({5'b0, (x == 0 && y == 0), (x == w - 1),
                                 (x == w - 1 && y == h - 1), 12'(x), 12'(y)});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),      32'd0);
        check({tag, "_done"},   32'(done),      32'd0);
        check({tag, "_err"},    32'(err_cfg),   32'd0);
        check({tag, "_flags"},  32'({sof, eol, eof}), 32'd0);
        check({tag, "_upry"},   32'(up_TREADY), 32'd0);
        check({tag, "_dpvld"},  32'(dp_TVALID), 32'd0);
        check({tag, "_xy"},     32'({x_cnt, y_cnt}), 32'd0);
        check({tag, "_frames"}, 32'(frame_cnt), 32'd0);
    endtask

    // Drive continuous valid; pop and compare one scoreboard entry per accepted beat.
    task automatic run(input string tag, input int ready_mode, input int chg_at,
                       input int chg_w, input int abort_at, input int rst_at,
                       input int exp_frames);
        int beat_i  = 0;
        int cyc     = 0;
        bit stopped = 1'b0;
        logic [31:0] e;
        while (exp_q.size() > 0 && cyc < 1000 && !stopped) begin
            up_TVALID = 1'b1;
            dp_TREADY = (ready_mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            cfg_abort = (beat_i == abort_at);
            #1;
            if (ready_mode == 1) check({tag, "_tready_mirror"}, 32'(up_TREADY), 32'(dp_TREADY));
            if (up_TVALID && up_TREADY) begin
                e = exp_q.pop_front();
                check({tag, "_beat"}, {5'b0, sof, eol, eof, x_cnt, y_cnt}, e);
                if (beat_i == chg_at) cfg_width = 12'(chg_w);
                if (beat_i == abort_at) begin
                    tick();
                    cfg_abort = 1'b0;
                    check({tag, "_abort_busy"},   32'(busy),      32'd0);
                    check({tag, "_abort_xy"},     32'({x_cnt, y_cnt}), 32'd0);
                    check({tag, "_abort_frames"}, 32'(frame_cnt), 32'd0);
                    check({tag, "_abort_done"},   32'(done),      32'd0);
                    tick();
                    check({tag, "_abort_nodone"}, 32'(done),      32'd0);
                    exp_q.delete();
                    stopped = 1'b1;
                end else if (beat_i == rst_at) begin
                    ARESETn = 1'b0;
                    #1;
                    check_reset_outputs({tag, "_rst"});
                    exp_q.delete();
                    stopped = 1'b1;
                end
                beat_i++;
            end
            if (!stopped) tick();
            cyc++;
        end
        if (!stopped) begin
            check({tag, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
            check({tag, "_done_pulse"}, 32'({done, busy, dp_TVALID}), 32'b110);
            tick();
            check({tag, "_done_clear"}, 32'({done, busy}), 32'b00);
            check({tag, "_frame_cnt"},  32'(frame_cnt), 32'(exp_frames));
        end
        cfg_abort = 1'b0;
    endtask

    initial begin
        ARESETn    = 1'b0;
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        cfg_width  = 12'd0;
        cfg_height = 12'd0;
        cfg_frames = 16'd0;
        up_TVALID  = 1'b1;
        dp_TREADY  = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check_reset_outputs("reset");
        ARESETn = 1'b1;
        tick();

        // 4x3, two frames, continuous flow.
        start(4, 3, 2);
        push_frame(4, 3);
        push_frame(4, 3);
        run("cont", 0, -1, 0, -1, -1, 2);

        // Same config, ready toggling every cycle.
        start(4, 3, 2);
        push_frame(4, 3);
        push_frame(4, 3);
        run("toggle", 1, -1, 0, -1, -1, 2);

        // Illegal width rejected, then a legal start clears the error.
        start(2, 3, 2);
        check("err_set",   32'(err_cfg),   32'd1);
        check("err_busy",  32'(busy),      32'd0);
        check("err_upry",  32'(up_TREADY), 32'd0);
        start(4, 3, 2);
        check("err_clear", 32'({err_cfg, busy}), 32'b01);

        // Abort at beat 7 of the sequence just started.
        push_frame(4, 3);
        push_frame(4, 3);
        run("abort", 0, -1, 0, 7, -1, 0);

        // Width rewritten mid-frame applies only from the next frame.
        start(4, 3, 2);
        push_frame(4, 3);
        push_frame(6, 3);
        run("resize", 0, 5, 6, -1, -1, 2);

        // Asynchronous reset mid-frame in continuous mode, then a fresh single frame.
        start(4, 3, 0);
        push_frame(4, 3);
        push_frame(4, 3);
        run("midrst", 0, -1, 0, -1, 9, 0);
        tick();
        ARESETn = 1'b1;
        tick();
        start(4, 3, 1);
        push_frame(4, 3);
        run("postrst", 0, -1, 0, -1, -1, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
